// File: rtl/binary_morph_nxn.sv
// Binary erode/dilate over a KSIZE x KSIZE trailing window, with run-time mode
// latched per frame, 2-clock latency and a per-frame geometry error flag.
module binary_morph_nxn #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int KSIZE     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic       frame_err
);
    localparam int COL_W  = $clog2(IMG_HDISP + 1);
    localparam int ROW_W  = $clog2(IMG_VDISP + 2);
    localparam int ADDR_W = $clog2(IMG_HDISP);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(IMG_HDISP);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_VDISP);
    localparam logic [ROW_W-1:0]  ROW_SAT   = ROW_W'(IMG_VDISP + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_HDISP - 1);
    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_ERODE  = 2'b01;
    localparam logic [1:0] MODE_DILATE = 2'b10;

    logic              r_vsync_d, r_href_d, r_vs_low_seen, r_armed;
    logic [COL_W-1:0]  r_col;
    logic              r_line_over;
    logic [ROW_W-1:0]  r_row;
    logic [1:0]        r_mode;
    logic              r_err_acc, r_frame_err;
    logic [IMG_HDISP-1:0] r_lbuf [KSIZE-1];
    logic [KSIZE-1:0]  r_win [KSIZE];
    logic [KSIZE-1:0]  r_rmask, r_cmask;
    logic              r_vs_s1, r_hs_s1, r_ck_s1, r_pix_s1;
    logic              r_post_vs, r_post_hs, r_post_ck, r_post_bit;

    logic              w_pix_en, w_vs_rise, w_vs_fall, w_hs_fall, w_line_bad;
    logic              w_row_inc, w_wr_en;
    logic [ROW_W-1:0]  w_row_eff, w_row_next;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [KSIZE-1:0]  w_col_in, w_rmask, w_cmask;
    logic              w_and, w_or, w_result;

    // A rising edge only counts once vsync has been seen low, so a reset released
    // mid-frame does not mistake the ongoing frame for a new one.
    assign w_pix_en   = per_frame_clken & per_frame_href;
    assign w_vs_rise  = per_frame_vsync & ~r_vsync_d & r_vs_low_seen;
    assign w_vs_fall  = ~per_frame_vsync & r_vsync_d;
    assign w_hs_fall  = ~per_frame_href & r_href_d;
    assign w_line_bad = (r_col != COL_END) | r_line_over;
    assign w_row_inc  = r_armed & w_hs_fall & (r_row != ROW_SAT);
    assign w_row_next = w_row_inc ? r_row + 1'b1 : r_row;
    assign w_row_eff  = w_vs_rise ? '0 : r_row;
    assign w_rd_addr  = (r_col == COL_END) ? ADDR_LAST : r_col[ADDR_W-1:0];
    assign w_wr_en    = w_pix_en & (r_col != COL_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d     <= 1'b0;
            r_href_d      <= 1'b0;
            r_vs_low_seen <= 1'b0;
            r_armed       <= 1'b0;
            r_col         <= '0;
            r_line_over   <= 1'b0;
            r_row         <= '0;
            r_mode        <= MODE_BYPASS;
            r_err_acc     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_vsync_d <= per_frame_vsync;
            r_href_d  <= per_frame_href;
            if (!per_frame_vsync) r_vs_low_seen <= 1'b1;
            if (w_hs_fall) begin
                r_col       <= '0;
                r_line_over <= 1'b0;
            end else if (w_pix_en) begin
                if (r_col != COL_END) r_col <= r_col + 1'b1;
                else                  r_line_over <= 1'b1;
            end
            if (w_vs_rise) begin
                r_row   <= '0;
                r_armed <= 1'b1;
                r_mode  <= mode;
            end else if (w_row_inc) begin
                r_row <= r_row + 1'b1;
            end
            // The closing line's check folds into the frame verdict on the same edge.
            if (w_vs_fall) begin
                r_frame_err <= r_err_acc | (w_hs_fall & w_line_bad) | (w_row_next != ROW_END);
                r_err_acc   <= 1'b0;
            end else if (w_hs_fall & w_line_bad) begin
                r_err_acc <= 1'b1;
            end
        end
    end

    always_comb begin
        w_col_in    = '0;
        w_col_in[0] = per_img_Bit;
        for (int k = 1; k < KSIZE; k++) w_col_in[k] = r_lbuf[k-1][w_rd_addr];
        w_rmask = '0;
        w_cmask = '0;
        for (int i = 0; i < KSIZE; i++) begin
            w_rmask[i] = (w_row_eff >= ROW_W'(i));
            w_cmask[i] = (r_col >= COL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < KSIZE - 1; k++) r_lbuf[k][w_rd_addr] <= w_col_in[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int dy = 0; dy < KSIZE; dy++) r_win[dy] <= '0;
            r_rmask  <= '0;
            r_cmask  <= '0;
            r_vs_s1  <= 1'b0;
            r_hs_s1  <= 1'b0;
            r_ck_s1  <= 1'b0;
            r_pix_s1 <= 1'b0;
        end else begin
            r_vs_s1  <= per_frame_vsync;
            r_hs_s1  <= per_frame_href;
            r_ck_s1  <= per_frame_clken;
            r_pix_s1 <= w_pix_en;
            if (w_pix_en) begin
                for (int dy = 0; dy < KSIZE; dy++)
                    r_win[dy] <= {r_win[dy][KSIZE-2:0], w_col_in[dy]};
                r_rmask <= w_rmask;
                r_cmask <= w_cmask;
            end
        end
    end

    // Taps outside the image become the neutral element of the reduction.
    always_comb begin
        w_and = 1'b1;
        w_or  = 1'b0;
        for (int dy = 0; dy < KSIZE; dy++) begin
            for (int dx = 0; dx < KSIZE; dx++) begin
                w_and = w_and & (r_win[dy][dx] | ~(r_rmask[dy] & r_cmask[dx]));
                w_or  = w_or | (r_win[dy][dx] & r_rmask[dy] & r_cmask[dx]);
            end
        end
        w_result = r_win[0][0];
        case (r_mode)
            MODE_ERODE:  w_result = w_and;
            MODE_DILATE: w_result = w_or;
            default:     w_result = r_win[0][0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_vs  <= 1'b0;
            r_post_hs  <= 1'b0;
            r_post_ck  <= 1'b0;
            r_post_bit <= 1'b0;
        end else begin
            r_post_vs <= r_vs_s1;
            r_post_hs <= r_hs_s1;
            r_post_ck <= r_ck_s1;
            if (r_pix_s1) r_post_bit <= w_result;
        end
    end

    assign post_frame_vsync = r_post_vs;
    assign post_frame_href  = r_post_hs;
    assign post_frame_clken = r_post_ck;
    assign post_img_Bit     = r_post_bit;
    assign frame_err        = r_frame_err;
endmodule

// File: tb/tb_binary_morph_nxn.sv
// Randomized bench for binary_morph_nxn on a reduced 16x12 frame: drivers push
// expected pixels from a direct window model, a negedge monitor pops and compares.
module tb_binary_morph_nxn;
    localparam int HD = 16;
    localparam int VD = 12;
    localparam int K  = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic       vs     = 1'b0;
    logic       hs     = 1'b0;
    logic       ck     = 1'b0;
    logic       bit_in = 1'b0;
    logic       post_vs, post_hs, post_ck, post_bit, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    // Entry = {dont_care, value}
    logic [1:0] exp_q[$];
    logic       img [VD+2][HD+2];
    logic [2:0] sh0 = '0;
    logic [2:0] sh1 = '0;
    int         hist_n = 0;

    always #5 clk = ~clk;

    binary_morph_nxn #(.IMG_HDISP(HD), .IMG_VDISP(VD), .KSIZE(K)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mode             (mode),
        .per_frame_vsync  (vs),
        .per_frame_href   (hs),
        .per_frame_clken  (ck),
        .per_img_Bit      (bit_in),
        .post_frame_vsync (post_vs),
        .post_frame_href  (post_hs),
        .post_frame_clken (post_ck),
        .post_img_Bit     (post_bit),
        .frame_err        (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    endtask

    // Output (r,c) = reduction over input rows r-K+1..r, cols c-K+1..c; outside = neutral.
    function automatic logic ref_pix(input int r, input int c, input logic [1:0] m);
        logic acc;
        if (m == 2'b01 || m == 2'b10) begin
            acc = (m == 2'b01);
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    if (r - i >= 0 && c - j >= 0) begin
                        if (m == 2'b01) acc = acc & img[r-i][c-j];
                        else            acc = acc | img[r-i][c-j];
                    end
        end else begin
            acc = img[r][c];
        end
        return acc;
    endfunction

    task automatic gen_img(input int pat, input int dens);
        for (int r = 0; r < VD + 2; r++)
            for (int c = 0; c < HD + 2; c++)
                case (pat)
                    1:       img[r][c] = (r >= 3 && r <= 8 && c >= 3 && c <= 8);
                    2:       img[r][c] = 1'b1;
                    3:       img[r][c] = (r == 5 && c == 9);
                    default: img[r][c] = (int'($urandom_range(0, 99)) < dens);
                endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nlines lines; short_line/long_line carry HD-1/HD+1 pixels; rst_row pulses reset mid-line.
    task automatic drive_frame(input int nlines, input int short_line, input int long_line,
                               input int duty, input int mid_mode, input int rst_row);
        logic [1:0] fmode;
        logic       bad;
        logic       partial;
        int         npix;
        int         c;
        bad = (nlines != VD) || (short_line >= 0) || (long_line >= 0);
        partial = 1'b0;
        repeat (4) begin tick(); ck = 1'($urandom_range(0, 1)); end
        fmode = mode;
        tick(); vs = 1'b1; ck = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < nlines; r++) begin
            if (mid_mode >= 0 && r == nlines / 2) mode = 2'(mid_mode);
            npix = (r == short_line) ? HD - 1 : (r == long_line) ? HD + 1 : HD;
            c = 0;
            while (c < npix) begin
                tick();
                hs = 1'b1;
                if (r == rst_row && c == 5 && !partial) begin
                    partial = 1'b1;
                    rst_n = 1'b0;
                    ck = 1'b0;
                    exp_q.delete();
                    #1;
                    chk("reset_forces_zero", 32'({post_vs, post_hs, post_ck, post_bit, frame_err}), 32'd0);
                    repeat (3) begin
                        tick();
                        ck = 1'($urandom_range(0, 1));
                        bit_in = 1'($urandom_range(0, 1));
                    end
                    tick();
                    rst_n = 1'b1;
                    ck = 1'b0;
                    continue;
                end
                ck = (int'($urandom_range(0, 99)) < duty);
                if (ck) begin
                    bit_in = img[r][c];
                    if (c >= HD)      exp_q.push_back(2'b10);
                    else if (partial) exp_q.push_back({1'b0, img[r][c]});
                    else              exp_q.push_back({1'b0, ref_pix(r, c, fmode)});
                    c++;
                end else begin
                    bit_in = 1'($urandom_range(0, 1));
                end
            end
            tick(); hs = 1'b0; ck = 1'($urandom_range(0, 1));
            repeat (3) begin tick(); ck = 1'($urandom_range(0, 1)); end
        end
        repeat (2) tick();
        vs = 1'b0; ck = 1'b0;
        repeat (3) tick();
        chk("frame_err", 32'(frame_err), 32'(bad | partial));
    endtask

    // Monitor: syncs must equal the inputs seen two clocks earlier; pixels pop the scoreboard.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            hist_n = 0;
        end else begin
            if (hist_n >= 2) chk("sync_delay", 32'({post_vs, post_hs, post_ck}), 32'(sh1));
            sh1 = sh0;
            sh0 = {vs, hs, ck};
            if (hist_n < 2) hist_n++;
            if (post_ck && post_hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pixel_unexpected: got %0b, expected no pixel at %0t", post_bit, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (!e[1]) chk("pixel", 32'(post_bit), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d checks made", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'({post_vs, post_hs, post_ck, post_bit, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        gen_img(0, 50); mode = 2'b00; drive_frame(VD, -1, -1, 100, -1, -1);
        gen_img(1, 0);  mode = 2'b01; drive_frame(VD, -1, -1, 100, -1, -1);
        gen_img(2, 0);  mode = 2'b01; drive_frame(VD, -1, -1, 100, -1, -1);
        gen_img(3, 0);  mode = 2'b10; drive_frame(VD, -1, -1, 100, -1, -1);
        // Bypass frame with a mid-frame switch to erode; the following frame erodes.
        gen_img(0, 50); mode = 2'b00; drive_frame(VD, -1, -1, 100, 1, -1);
        gen_img(0, 85);               drive_frame(VD, -1, -1, 100, -1, -1);
        gen_img(0, 50); mode = 2'b00; drive_frame(VD - 1, 7, -1, 100, -1, -1);
        gen_img(0, 10); mode = 2'b10; drive_frame(VD, -1, -1, 100, -1, -1);
        gen_img(0, 85); mode = 2'b01; drive_frame(VD, -1, 2, 100, -1, -1);
        gen_img(0, 50); mode = 2'b00; drive_frame(VD + 1, -1, -1, 100, -1, -1);
        gen_img(0, 70); mode = 2'b01; drive_frame(VD, -1, -1, 50, -1, 6);
        gen_img(0, 70);               drive_frame(VD, -1, -1, 50, -1, -1);
        gen_img(0, 20); mode = 2'b10; drive_frame(VD, -1, -1, 50, -1, -1);
        gen_img(0, 50); mode = 2'b11; drive_frame(VD, -1, -1, 100, -1, -1);

        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
